// File: rtl/decode_stage_if.sv
// Fetch/decode/issue signal bundle for the RV32I decode stage.
// The slave modport is the decode stage's view; master is the fetch/issue environment.
interface decode_stage_if #(
  parameter int ADDR = 32,
  parameter int INST = 32,
  parameter int DATA = 32
);
  logic            flush;
  logic            inst_e_;
  logic [ADDR-1:0] inst_pc;
  logic [INST-1:0] inst;
  logic            dec_stall;
  logic            is_full;
  logic            dec_e_;
  logic [ADDR-1:0] dec_pc;
  logic [INST-1:0] dec_inst;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rd_en;
  logic            rs1_en;
  logic            rs2_en;
  logic [DATA-1:0] imm;
  logic            src1_pc;
  logic            src2_imm;
  logic [1:0]      unit;
  logic [3:0]      alu_op;
  logic [3:0]      sub_op;
  logic            illegal;

  modport slave (
    input  flush, inst_e_, inst_pc, inst, is_full,
    output dec_stall, dec_e_, dec_pc, dec_inst, rd, rs1, rs2,
           rd_en, rs1_en, rs2_en, imm, src1_pc, src2_imm,
           unit, alu_op, sub_op, illegal
  );

  modport master (
    output flush, inst_e_, inst_pc, inst, is_full,
    input  dec_stall, dec_e_, dec_pc, dec_inst, rd, rs1, rs2,
           rd_en, rs1_en, rs2_en, imm, src1_pc, src2_imm,
           unit, alu_op, sub_op, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into one output register.
// Define DECODE_MEXT_EN to accept the M-extension (OP, funct7=0x01) as MULDIV ops.
module decode_stage #(
  parameter int ADDR = 32,
  parameter int INST = 32,
  parameter int DATA = 32
) (
  input  logic           clk,
  input  logic           reset,
  decode_stage_if.slave  bus
);

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  localparam logic [1:0] UNIT_ALU    = 2'd0;
  localparam logic [1:0] UNIT_MULDIV = 2'd1;
  localparam logic [1:0] UNIT_MEM    = 2'd2;
  localparam logic [1:0] UNIT_BRANCH = 2'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_COPY = 4'd10;

  localparam logic [3:0] SUB_JAL  = 4'hA;
  localparam logic [3:0] SUB_JALR = 4'hB;

  typedef struct packed {
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_en;
    logic            rs1_en;
    logic            rs2_en;
    logic [DATA-1:0] imm;
    logic            src1_pc;
    logic            src2_imm;
    logic [1:0]      unit;
    logic [3:0]      alu_op;
    logic [3:0]      sub_op;
    logic            illegal;
  } dec_t;

  function automatic logic signed [31:0] imm_i(input logic [31:0] w);
    return $signed({{20{w[31]}}, w[31:20]});
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] w);
    return $signed({{20{w[31]}}, w[31:25], w[11:7]});
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] w);
    return $signed({{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0});
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] w);
    return $signed({w[31:12], 12'b0});
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] w);
    return $signed({{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0});
  endfunction

  function automatic logic [DATA-1:0] sext(input logic signed [31:0] v);
    return DATA'(v);
  endfunction

  // funct3 -> ALU op; alt selects SUB/SRA where funct7[5] is set
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [31:0] ins_p0;
  logic [6:0]  opc_p0;
  logic [2:0]  f3_p0;
  logic [6:0]  f7_p0;
  logic        bad_p0;
  dec_t        dec_p0;

  assign ins_p0 = 32'(bus.inst);
  assign opc_p0 = ins_p0[6:0];
  assign f3_p0  = ins_p0[14:12];
  assign f7_p0  = ins_p0[31:25];

  // Stage p0: combinational decode of the word presented by fetch
  always_comb begin
    dec_p0        = '0;
    bad_p0        = 1'b0;
    dec_p0.rd     = ins_p0[11:7];
    dec_p0.rs1    = ins_p0[19:15];
    dec_p0.rs2    = ins_p0[24:20];
    dec_p0.unit   = UNIT_ALU;
    dec_p0.alu_op = ALU_ADD;

    case (opc_p0)
      OPC_OP_IMM: begin
        dec_p0.rd_en    = 1'b1;
        dec_p0.rs1_en   = 1'b1;
        dec_p0.src2_imm = 1'b1;
        dec_p0.imm      = sext(imm_i(ins_p0));
        dec_p0.alu_op   = alu_from_f3(f3_p0, 1'b0);
        if (f3_p0 == 3'b001 && f7_p0 != 7'h00) bad_p0 = 1'b1;
        if (f3_p0 == 3'b101) begin
          if (f7_p0 == 7'h20)      dec_p0.alu_op = ALU_SRA;
          else if (f7_p0 != 7'h00) bad_p0 = 1'b1;
        end
      end
      OPC_OP: begin
        dec_p0.rd_en  = 1'b1;
        dec_p0.rs1_en = 1'b1;
        dec_p0.rs2_en = 1'b1;
        if (f7_p0 == 7'h00) begin
          dec_p0.alu_op = alu_from_f3(f3_p0, 1'b0);
        end else if (f7_p0 == 7'h20) begin
          dec_p0.alu_op = alu_from_f3(f3_p0, 1'b1);
          if (f3_p0 != 3'b000 && f3_p0 != 3'b101) bad_p0 = 1'b1;
        end else if (f7_p0 == 7'h01) begin
`ifdef DECODE_MEXT_EN
          dec_p0.unit   = UNIT_MULDIV;
          dec_p0.sub_op = {1'b0, f3_p0};
`else
          bad_p0 = 1'b1;
`endif
        end else begin
          bad_p0 = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_p0.rd_en    = 1'b1;
        dec_p0.src2_imm = 1'b1;
        dec_p0.alu_op   = ALU_COPY;
        dec_p0.imm      = sext(imm_u(ins_p0));
      end
      OPC_AUIPC: begin
        dec_p0.rd_en    = 1'b1;
        dec_p0.src1_pc  = 1'b1;
        dec_p0.src2_imm = 1'b1;
        dec_p0.imm      = sext(imm_u(ins_p0));
      end
      OPC_LOAD: begin
        dec_p0.unit     = UNIT_MEM;
        dec_p0.sub_op   = {1'b0, f3_p0};
        dec_p0.rd_en    = 1'b1;
        dec_p0.rs1_en   = 1'b1;
        dec_p0.src2_imm = 1'b1;
        dec_p0.imm      = sext(imm_i(ins_p0));
        if (f3_p0 == 3'b011 || f3_p0 == 3'b110 || f3_p0 == 3'b111) bad_p0 = 1'b1;
      end
      OPC_STORE: begin
        dec_p0.unit     = UNIT_MEM;
        dec_p0.sub_op   = {1'b1, f3_p0};
        dec_p0.rs1_en   = 1'b1;
        dec_p0.rs2_en   = 1'b1;
        dec_p0.src2_imm = 1'b1;
        dec_p0.imm      = sext(imm_s(ins_p0));
        if (f3_p0[2] || f3_p0 == 3'b011) bad_p0 = 1'b1;
      end
      OPC_BRANCH: begin
        dec_p0.unit   = UNIT_BRANCH;
        dec_p0.sub_op = {1'b0, f3_p0};
        dec_p0.rs1_en = 1'b1;
        dec_p0.rs2_en = 1'b1;
        dec_p0.imm    = sext(imm_b(ins_p0));
        if (f3_p0 == 3'b010 || f3_p0 == 3'b011) bad_p0 = 1'b1;
      end
      OPC_JAL: begin
        dec_p0.unit     = UNIT_BRANCH;
        dec_p0.sub_op   = SUB_JAL;
        dec_p0.rd_en    = 1'b1;
        dec_p0.src1_pc  = 1'b1;
        dec_p0.src2_imm = 1'b1;
        dec_p0.imm      = sext(imm_j(ins_p0));
      end
      OPC_JALR: begin
        dec_p0.unit     = UNIT_BRANCH;
        dec_p0.sub_op   = SUB_JALR;
        dec_p0.rd_en    = 1'b1;
        dec_p0.rs1_en   = 1'b1;
        dec_p0.src2_imm = 1'b1;
        dec_p0.imm      = sext(imm_i(ins_p0));
        if (f3_p0 != 3'b000) bad_p0 = 1'b1;
      end
      default: bad_p0 = 1'b1;
    endcase

    if (ins_p0[1:0] != 2'b11) bad_p0 = 1'b1;

    // Illegal words keep their raw indices for the exception path but enable nothing
    if (bad_p0) begin
      dec_p0.rd_en    = 1'b0;
      dec_p0.rs1_en   = 1'b0;
      dec_p0.rs2_en   = 1'b0;
      dec_p0.imm      = '0;
      dec_p0.src1_pc  = 1'b0;
      dec_p0.src2_imm = 1'b0;
      dec_p0.unit     = UNIT_ALU;
      dec_p0.alu_op   = ALU_ADD;
      dec_p0.sub_op   = 4'd0;
      dec_p0.illegal  = 1'b1;
    end

    if (dec_p0.rd == 5'd0) dec_p0.rd_en = 1'b0;
  end

  dec_t            dec_p1;
  logic [ADDR-1:0] pc_p1;
  logic [INST-1:0] inst_p1;
  logic            vld_p1;

  // Stage p1: output register toward issue; flush only invalidates, fields hold
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      dec_p1  <= '0;
      pc_p1   <= '0;
      inst_p1 <= '0;
    end else if (bus.flush) begin
      vld_p1  <= 1'b0;
    end else if (!bus.is_full) begin
      vld_p1  <= !bus.inst_e_;
      dec_p1  <= dec_p0;
      pc_p1   <= bus.inst_pc;
      inst_p1 <= bus.inst;
    end
  end

  assign bus.dec_stall = bus.is_full;
  assign bus.dec_e_    = !vld_p1;
  assign bus.dec_pc    = pc_p1;
  assign bus.dec_inst  = inst_p1;
  assign bus.rd        = dec_p1.rd;
  assign bus.rs1       = dec_p1.rs1;
  assign bus.rs2       = dec_p1.rs2;
  assign bus.rd_en     = dec_p1.rd_en;
  assign bus.rs1_en    = dec_p1.rs1_en;
  assign bus.rs2_en    = dec_p1.rs2_en;
  assign bus.imm       = dec_p1.imm;
  assign bus.src1_pc   = dec_p1.src1_pc;
  assign bus.src2_imm  = dec_p1.src2_imm;
  assign bus.unit      = dec_p1.unit;
  assign bus.alu_op    = dec_p1.alu_op;
  assign bus.sub_op    = dec_p1.sub_op;
  assign bus.illegal   = dec_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table through a scoreboard plus stall/flush/reset sequences.
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if #(.ADDR(32), .INST(32), .DATA(32)) bus ();

  decode_stage #(.ADDR(32), .INST(32), .DATA(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ill;
    logic [1:0]  unit;
    logic [3:0]  alu;
    logic [3:0]  sub;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  en;   // {rd_en, rs1_en, rs2_en}
    logic [1:0]  src;  // {src1_pc, src2_imm}
    logic [31:0] imm;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(string nm, logic [31:0] inst, logic [31:0] pc, logic ill,
                              logic [1:0] unit, logic [3:0] alu, logic [3:0] sub,
                              logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [2:0] en, logic [1:0] src, logic [31:0] imm);
    vec_t v;
    v.nm = nm; v.inst = inst; v.pc = pc; v.ill = ill; v.unit = unit; v.alu = alu;
    v.sub = sub; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.en = en; v.src = src; v.imm = imm;
    return v;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Fields the encoding leaves open (unused indices, op selects of other units) are masked
  task automatic cmp_vec(vec_t e);
    logic legal, is_alu;
    logic [127:0] act, exp;
    legal  = !e.ill;
    is_alu = (e.unit == 2'd0);
    exp = 128'({e.pc, e.inst, e.ill, e.unit, e.en,
                e.en[2] ? e.rd : 5'd0, e.en[1] ? e.rs1 : 5'd0, e.en[0] ? e.rs2 : 5'd0,
                (legal && is_alu) ? e.alu : 4'd0, (legal && !is_alu) ? e.sub : 4'd0,
                legal ? e.src[1] : 1'b0, (legal && is_alu) ? e.src[0] : 1'b0,
                legal ? e.imm : 32'd0});
    act = 128'({bus.dec_pc, bus.dec_inst, bus.illegal, bus.unit,
                {bus.rd_en, bus.rs1_en, bus.rs2_en},
                e.en[2] ? bus.rd : 5'd0, e.en[1] ? bus.rs1 : 5'd0, e.en[0] ? bus.rs2 : 5'd0,
                (legal && is_alu) ? bus.alu_op : 4'd0, (legal && !is_alu) ? bus.sub_op : 4'd0,
                legal ? bus.src1_pc : 1'b0, (legal && is_alu) ? bus.src2_imm : 1'b0,
                legal ? bus.imm : 32'd0});
    check({"dec_", e.nm}, act, exp);
  endtask

  function automatic logic [127:0] all_out();
    return 128'({bus.dec_pc, bus.dec_inst, bus.rd, bus.rs1, bus.rs2,
                 bus.rd_en, bus.rs1_en, bus.rs2_en, bus.imm, bus.src1_pc, bus.src2_imm,
                 bus.unit, bus.alu_op, bus.sub_op, bus.illegal});
  endfunction

  // Monitor: an accepted valid instruction must appear, decoded, after the edge
  always @(posedge clk) begin
    logic acc;
    acc = !reset && !bus.flush && !bus.is_full && !bus.inst_e_;
    #1;
    if (acc) begin
      check("dec_e_valid", 128'(bus.dec_e_), 128'(1'b0));
      if (sb.size() == 0) check("sb_underflow", 128'(1), 128'(0));
      else cmp_vec(sb.pop_front());
    end
  end

  task automatic issue(vec_t v);
    @(negedge clk);
    reset       = 1'b0;
    bus.flush   = 1'b0;
    bus.is_full = 1'b0;
    bus.inst_e_ = 1'b0;
    bus.inst    = v.inst;
    bus.inst_pc = v.pc;
    sb.push_back(v);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.is_full = 1'b0;
    bus.inst_e_ = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t prev, v_addi, v_add, v_sub;

    tbl.push_back(mk("addi",  32'h00510093, 32'h100, 0, 2'd0, 4'd0,  4'd0, 5'd1, 5'd2,  5'd0, 3'b110, 2'b01, 32'd5));
    tbl.push_back(mk("lw",    32'hFFC52283, 32'h104, 0, 2'd2, 4'd0,  4'h2, 5'd5, 5'd10, 5'd0, 3'b110, 2'b01, 32'hFFFFFFFC));
    tbl.push_back(mk("sw",    32'h0063A423, 32'h108, 0, 2'd2, 4'd0,  4'hA, 5'd0, 5'd7,  5'd6, 3'b011, 2'b01, 32'd8));
    tbl.push_back(mk("lui",   32'h123451B7, 32'h10C, 0, 2'd0, 4'd10, 4'd0, 5'd3, 5'd0,  5'd0, 3'b100, 2'b01, 32'h12345000));
    tbl.push_back(mk("add",   32'h002081B3, 32'h110, 0, 2'd0, 4'd0,  4'd0, 5'd3, 5'd1,  5'd2, 3'b111, 2'b00, 32'd0));
    tbl.push_back(mk("sub",   32'h407302B3, 32'h114, 0, 2'd0, 4'd1,  4'd0, 5'd5, 5'd6,  5'd7, 3'b111, 2'b00, 32'd0));
    tbl.push_back(mk("sra",   32'h403150B3, 32'h118, 0, 2'd0, 4'd7,  4'd0, 5'd1, 5'd2,  5'd3, 3'b111, 2'b00, 32'd0));
    tbl.push_back(mk("srai",  32'h40325213, 32'h11C, 0, 2'd0, 4'd7,  4'd0, 5'd4, 5'd4,  5'd0, 3'b110, 2'b01, 32'h403));
    tbl.push_back(mk("slti",  32'hFFF1A113, 32'h120, 0, 2'd0, 4'd3,  4'd0, 5'd2, 5'd3,  5'd0, 3'b110, 2'b01, 32'hFFFFFFFF));
    tbl.push_back(mk("auipc", 32'hFFFFF397, 32'h124, 0, 2'd0, 4'd0,  4'd0, 5'd7, 5'd0,  5'd0, 3'b100, 2'b11, 32'hFFFFF000));
    tbl.push_back(mk("beq",   32'hFE208CE3, 32'h128, 0, 2'd3, 4'd0,  4'd0, 5'd0, 5'd1,  5'd2, 3'b011, 2'b00, 32'hFFFFFFF8));
    tbl.push_back(mk("jal",   32'h010000EF, 32'h12C, 0, 2'd3, 4'd0,  4'hA, 5'd1, 5'd0,  5'd0, 3'b100, 2'b10, 32'd16));
    tbl.push_back(mk("jalr",  32'h00008067, 32'h130, 0, 2'd3, 4'd0,  4'hB, 5'd0, 5'd1,  5'd0, 3'b010, 2'b00, 32'd0));
    tbl.push_back(mk("nop",   32'h00000013, 32'h134, 0, 2'd0, 4'd0,  4'd0, 5'd0, 5'd0,  5'd0, 3'b010, 2'b01, 32'd0));
    tbl.push_back(mk("ld_rsv",32'h00003003, 32'h138, 1, 2'd0, 4'd0,  4'd0, 5'd0, 5'd0,  5'd0, 3'b000, 2'b00, 32'd0));
    tbl.push_back(mk("lowbit",32'h00510090, 32'h13C, 1, 2'd0, 4'd0,  4'd0, 5'd0, 5'd0,  5'd0, 3'b000, 2'b00, 32'd0));
`ifdef DECODE_MEXT_EN
    tbl.push_back(mk("mul",   32'h023100B3, 32'h140, 0, 2'd1, 4'd0,  4'd0, 5'd1, 5'd2,  5'd3, 3'b111, 2'b00, 32'd0));
`else
    tbl.push_back(mk("mul",   32'h023100B3, 32'h140, 1, 2'd0, 4'd0,  4'd0, 5'd0, 5'd0,  5'd0, 3'b000, 2'b00, 32'd0));
`endif
    v_addi = tbl[0];
    v_add  = tbl[4];
    v_sub  = tbl[5];

    reset       = 1'b1;
    bus.flush   = 1'b0;
    bus.is_full = 1'b0;
    bus.inst_e_ = 1'b1;
    bus.inst    = '0;
    bus.inst_pc = '0;
    @(posedge clk); #1;
    check("rst_dec_e_", 128'(bus.dec_e_), 128'(1'b1));
    check("rst_fields", all_out(), 128'd0);
    check("rst_stall",  128'(bus.dec_stall), 128'(1'b0));

    prev = tbl[0];
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].nm == "lui") begin
        // Issue full for 3 cycles while fetch holds lui: previous result must hold
        @(negedge clk);
        bus.inst_e_ = 1'b0;
        bus.inst    = tbl[i].inst;
        bus.inst_pc = tbl[i].pc;
        bus.is_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          check("stall_flag", 128'(bus.dec_stall), 128'(1'b1));
          check("stall_hold", 128'({bus.dec_e_, bus.dec_pc, bus.dec_inst}),
                128'({1'b0, prev.pc, prev.inst}));
        end
      end
      issue(tbl[i]);
      prev = tbl[i];
    end
    idle();

    // Illegal word, then flush drops the instruction presented alongside it
    issue(mk("ffff", 32'hFFFFFFFF, 32'h200, 1, 2'd0, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 3'b000, 2'b00, 32'd0));
    @(negedge clk);
    bus.flush   = 1'b1;
    bus.inst_e_ = 1'b0;
    bus.inst    = v_addi.inst;
    bus.inst_pc = 32'h204;
    @(posedge clk); #1;
    check("flush_inval", 128'(bus.dec_e_), 128'(1'b1));

    // Flush wins over is_full
    issue(v_addi);
    @(negedge clk);
    bus.flush   = 1'b1;
    bus.is_full = 1'b1;
    bus.inst_e_ = 1'b0;
    @(posedge clk); #1;
    check("flush_full", 128'({bus.dec_e_, bus.dec_stall}), 128'(2'b11));

    // Invalid fetch input produces no valid output
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.is_full = 1'b0;
    bus.inst_e_ = 1'b1;
    @(posedge clk); #1;
    check("inst_inval", 128'(bus.dec_e_), 128'(1'b1));

    // Reset during a stall clears everything; held instruction goes through afterwards
    issue(v_add);
    @(negedge clk);
    bus.is_full = 1'b1;
    reset       = 1'b1;
    bus.inst_e_ = 1'b0;
    bus.inst    = v_sub.inst;
    bus.inst_pc = v_sub.pc;
    @(posedge clk); #1;
    check("rst_stall_e", 128'({bus.dec_e_, bus.dec_stall}), 128'(2'b11));
    check("rst_stall_f", all_out(), 128'd0);
    issue(v_sub);
    idle();

    repeat (3) @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode pipeline stage of the RV32I out-of-order core; sits between the fetch stage and the issue stage.
- Takes one fetched instruction per cycle with its PC, decodes it into register indices, immediate, execution-unit and operation selects, and presents the result in one output register to issue.
- Stalls fetch when issue reports full.
- A flush input discards the held instruction.

Parameters:
- ADDR, 32, PC/address width
- INST, 32, instruction width (must be 32)
- DATA, 32, data/immediate width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard output register contents (branch mispredict/exception)
- inst_e_  in  1  fetch instruction valid, active-low
- inst_pc  in  ADDR  PC of fetched instruction
- inst  in  INST  fetched instruction word
- dec_stall  out  1  to fetch: hold inst/inst_pc/inst_e_ this cycle
- is_full  in  1  issue queue cannot accept
- dec_e_  out  1  decoded instruction valid, active-low
- dec_pc  out  ADDR  PC of decoded instruction
- dec_inst  out  INST  raw instruction word
- rd, rs1, rs2  out  5 each  register indices
- rd_en, rs1_en, rs2_en  out  1 each  register actually written/read
- imm  out  DATA  sign-extended immediate
- src1_pc  out  1  operand 1 is PC (AUIPC, JAL)
- src2_imm  out  1  operand 2 is imm
- unit  out  2  0 ALU, 1 MULDIV, 2 MEM, 3 BRANCH
- alu_op  out  4  ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, COPY 10 (pass imm)
- sub_op  out  4  MEM: {store, funct3}; BRANCH: {0, funct3}, JAL 4'hA, JALR 4'hB; MULDIV: {0, funct3}
- illegal  out  1  unrecognised encoding

Behaviour:
- Combinational decode of inst feeds one output register: latency 1 cycle.
- Load condition: `!is_full`. When loading, dec_e_ <= inst_e_ and all fields are loaded. When is_full=1, all outputs hold.
- dec_stall = is_full (combinational). Fetch holds its inputs while dec_stall=1. No instruction is lost or duplicated.
- flush=1: dec_e_ <= 1 next cycle regardless of is_full. An instruction presented in that cycle is dropped. flush has priority over load.
- reset=1: dec_e_=1; all other outputs 0. Reset has priority over flush. Reset mid-stall clears everything.
- Immediates, all sign-extended to DATA:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R-type: imm=0.
- Opcodes:
  - OP-IMM (0x13): ALU, src2_imm. SRAI when funct7[5]=1.
  - OP (0x33): ALU. SUB/SRA when funct7=0x20.
  - LUI: ALU, COPY, src2_imm, rs1_en=0.
  - AUIPC: ALU, ADD, src1_pc, src2_imm.
  - LOAD (0x03): MEM, store=0.
  - STORE (0x23): MEM, store=1, rd_en=0.
  - BRANCH (0x63): rd_en=0.
  - JAL: BRANCH, src1_pc.
  - JALR: BRANCH.
- rd_en is forced 0 when rd=x0. rs*_en is 0 for fields the format lacks.
- Illegal: unknown opcode, reserved funct3/funct7 combinations, or inst[1:0]≠2'b11. Then illegal=1, unit=ALU, all *_en=0. dec_e_ still follows inst_e_ so the instruction is passed on for exception handling.
- Invalid input (inst_e_=1): fields are don't-care but still registered. The verifier checks fields only when dec_e_=0.

Optional Feature:
- DECODE_MEXT_EN defined: OP with funct7=0x01 decodes as unit=MULDIV, sub_op={0, funct3}, rs1/rs2/rd enabled.
- Undefined: that encoding decodes as illegal=1.

Test Plan:
- Reset 1 cycle, inst_e_=1 -> dec_e_=1, all fields 0, dec_stall=0.
- inst=0x00510093 (addi x1,x2,5), pc=0x100 -> next cycle dec_e_=0, dec_pc=0x100, rd=1, rs1=2, rs1_en=1, rs2_en=0, imm=5, unit=ALU, alu_op=ADD, src2_imm=1.
- Back-to-back 0xFFC52283 (lw x5,-4(x10)) then 0x0063A423 (sw x6,8(x7)):
  - first: unit=MEM, sub_op=4'h2, imm=0xFFFFFFFC, rd_en=1
  - second: sub_op=4'hA, imm=8, rd_en=0, rs2=6
- is_full=1 for 3 cycles while fetch holds 0x123451B7 (lui x3) -> outputs unchanged and dec_stall=1 each cycle. After release: rd=3, imm=0x12345000, alu_op=COPY.
- inst=0xFFFFFFFF -> illegal=1, dec_e_=0. flush=1 the following cycle -> dec_e_=1 next cycle.
- inst=0x023100B3 (mul x1,x2,x3):
  - with DECODE_MEXT_EN: unit=MULDIV, sub_op=0
  - without: illegal=1
